// File: rtl/i281_dmem_uart_dump.sv
// rtl/i281_dmem_uart_dump.sv - snapshot the i281 data memory and send it as one checksummed UART frame
module i281_dmem_uart_dump #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dump_req,
    input  logic [7:0] datamem0,
    input  logic [7:0] datamem1,
    input  logic [7:0] datamem2,
    input  logic [7:0] datamem3,
    input  logic [7:0] datamem4,
    input  logic [7:0] datamem5,
    input  logic [7:0] datamem6,
    input  logic [7:0] datamem7,
    input  logic [7:0] datamem8,
    input  logic [7:0] datamem9,
    input  logic [7:0] datamem10,
    input  logic [7:0] datamem11,
    input  logic [7:0] datamem12,
    input  logic [7:0] datamem13,
    input  logic [7:0] datamem14,
    input  logic [7:0] datamem15,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    LAST_BYTE = 5'd17;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [15:0][7:0] dm_w;
    logic [15:0][7:0] shadow_q, shadow_d;
    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [4:0]       byte_q, byte_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       chk_q, chk_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;

    assign dm_w = {datamem15, datamem14, datamem13, datamem12,
                   datamem11, datamem10, datamem9,  datamem8,
                   datamem7,  datamem6,  datamem5,  datamem4,
                   datamem3,  datamem2,  datamem1,  datamem0};

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = bit_end ? '0 : cnt_q + 1'b1;
        bit_d    = bit_q;
        byte_d   = byte_q;
        sh_d     = sh_q;
        chk_d    = chk_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (dump_req) begin
                    shadow_d = dm_w;
                    sh_d     = HEADER;
                    byte_d   = 5'd0;
                    chk_d    = 8'd0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = sh_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        sh_d  = {1'b0, sh_q[7:1]};
                        tx_d  = sh_q[1];
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // byte_q is the index just sent; byte_q==16 means the checksum goes next
                        state_d = S_START;
                        tx_d    = 1'b0;
                        byte_d  = byte_q + 5'd1;
                        if (byte_q[4]) begin
                            sh_d = chk_q;
                        end else begin
                            sh_d  = shadow_q[byte_q[3:0]];
                            chk_d = chk_q + shadow_q[byte_q[3:0]];
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            byte_q   <= 5'd0;
            sh_q     <= 8'd0;
            chk_q    <= 8'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            sh_q     <= sh_d;
            chk_q    <= chk_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_i281_dmem_uart_dump.sv
// tb/tb_i281_dmem_uart_dump.sv - scoreboard bench decoding both UART outputs against queued expected bytes
module tb_i281_dmem_uart_dump;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dump_req = 1'b0;
    logic       dump_req2 = 1'b0;
    logic [7:0] dm [16];
    logic       tx, busy, done;
    logic       tx2, busy2, done2;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int done2_cnt = 0;
    bit mon_en = 1'b1;
    logic [7:0] q [$];
    logic [7:0] q2 [$];

    always #5 clock = ~clock;

    i281_dmem_uart_dump #(.CLKS_PER_BIT(4), .HEADER(8'hA5)) dut (
        .clock(clock), .reset(reset), .dump_req(dump_req),
        .datamem0(dm[0]), .datamem1(dm[1]), .datamem2(dm[2]), .datamem3(dm[3]),
        .datamem4(dm[4]), .datamem5(dm[5]), .datamem6(dm[6]), .datamem7(dm[7]),
        .datamem8(dm[8]), .datamem9(dm[9]), .datamem10(dm[10]), .datamem11(dm[11]),
        .datamem12(dm[12]), .datamem13(dm[13]), .datamem14(dm[14]), .datamem15(dm[15]),
        .tx(tx), .busy(busy), .done(done)
    );

    i281_dmem_uart_dump #(.CLKS_PER_BIT(2), .HEADER(8'hA5)) dut2 (
        .clock(clock), .reset(reset), .dump_req(dump_req2),
        .datamem0(dm[0]), .datamem1(dm[1]), .datamem2(dm[2]), .datamem3(dm[3]),
        .datamem4(dm[4]), .datamem5(dm[5]), .datamem6(dm[6]), .datamem7(dm[7]),
        .datamem8(dm[8]), .datamem9(dm[9]), .datamem10(dm[10]), .datamem11(dm[11]),
        .datamem12(dm[12]), .datamem13(dm[13]), .datamem14(dm[14]), .datamem15(dm[15]),
        .tx(tx2), .busy(busy2), .done(done2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called on the first sampled cycle of a start bit; samples every cycle of all ten bits.
    task automatic decode_byte(input int sel, output logic [7:0] b, output bit clean, output bit aborted);
        logic [9:0] bits;
        logic       s;
        int         c;
        c       = (sel != 0) ? 2 : 4;
        clean   = 1'b1;
        aborted = 1'b0;
        bits    = '0;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < c; k++) begin
                if (!(i == 0 && k == 0)) @(negedge clock);
                if (!reset) aborted = 1'b1;
                s = (sel != 0) ? tx2 : tx;
                if (k == 0) bits[i] = s;
                else if (s !== bits[i]) clean = 1'b0;
            end
        end
        b = bits[8:1];
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) clean = 1'b0;
    endtask

    initial forever begin
        logic [7:0] b, e;
        bit clean, ab;
        @(negedge clock);
        if (reset && mon_en && tx === 1'b0) begin
            decode_byte(0, b, clean, ab);
            if (!ab) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL mon_byte: got unexpected byte %0h expected none", b);
                end else begin
                    e = q.pop_front();
                    if (b !== e || !clean) begin
                        fails++;
                        $display("FAIL mon_byte: got %0h (clean=%0d) expected %0h", b, clean, e);
                    end
                end
            end
        end
    end

    initial forever begin
        logic [7:0] b, e;
        bit clean, ab;
        @(negedge clock);
        if (reset && tx2 === 1'b0) begin
            decode_byte(1, b, clean, ab);
            if (!ab) begin
                tests++;
                if (q2.size() == 0) begin
                    fails++;
                    $display("FAIL mon2_byte: got unexpected byte %0h expected none", b);
                end else begin
                    e = q2.pop_front();
                    if (b !== e || !clean) begin
                        fails++;
                        $display("FAIL mon2_byte: got %0h (clean=%0d) expected %0h", b, clean, e);
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (done === 1'b1) done_cnt++;
        if (done2 === 1'b1) done2_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input logic [7:0] chk);
        q.push_back(8'hA5);
        for (int k = 0; k < 16; k++) q.push_back(dm[k]);
        q.push_back(chk);
    endtask

    task automatic run_frame(input logic [7:0] chk, input bit mut3, input logic [7:0] new3, input bit poke);
        int n;
        int d0;
        push_frame(chk);
        d0 = done_cnt;
        @(negedge clock); dump_req = 1'b1;
        @(negedge clock); dump_req = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_tx", {31'd0, tx}, 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge clock);
            dump_req = poke && (n == 365);
            if (mut3 && n == 1) dm[3] = new3;
        end
        check("busy_len", n, 720);
        check("done_at_end", {31'd0, done}, 32'd1);
        @(negedge clock);
        check("done_single", {31'd0, done}, 32'd0);
        check("done_count", done_cnt - d0, 1);
        repeat (2) @(negedge clock);
        check("queue_drained", q.size(), 0);
    endtask

    initial begin
        int n;
        int d0;
        bit ok;
        for (int k = 0; k < 16; k++) dm[k] = 8'(k + 1);
        #2 reset = 1'b0;
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_tx2", {31'd0, tx2}, 32'd1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        run_frame(8'h88, 1'b0, 8'h00, 1'b0);

        for (int k = 0; k < 16; k++) dm[k] = 8'hFF;
        run_frame(8'hF0, 1'b0, 8'h00, 1'b0);

        for (int k = 0; k < 16; k++) dm[k] = 8'(k + 1);
        dm[3] = 8'h11;
        run_frame(8'h95, 1'b1, 8'h22, 1'b0);
        check("dm3_changed", {24'd0, dm[3]}, 32'h22);
        run_frame(8'hA6, 1'b0, 8'h00, 1'b0);

        dm[3] = 8'd4;
        run_frame(8'h88, 1'b0, 8'h00, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (busy !== 1'b0 || tx !== 1'b1) ok = 1'b0;
        end
        check("no_queued_frame", {31'd0, ok}, 32'd1);

        mon_en = 1'b0;
        d0 = done_cnt;
        @(negedge clock); dump_req = 1'b1;
        @(negedge clock); dump_req = 1'b0;
        repeat (205) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
        end
        check("post_rst_idle", {31'd0, ok}, 32'd1);
        check("midrst_no_done", done_cnt - d0, 0);
        mon_en = 1'b1;

        for (int k = 0; k < 16; k++) dm[k] = 8'(k * 16);
        for (int f = 0; f < 2; f++) begin
            q2.push_back(8'hA5);
            for (int k = 0; k < 16; k++) q2.push_back(dm[k]);
            q2.push_back(8'h80);
        end
        d0 = done2_cnt;
        @(negedge clock); dump_req2 = 1'b1;
        n = 0;
        while (done2 !== 1'b1 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("held_done1", {31'd0, done2}, 32'd1);
        check("held_gap_tx", {31'd0, tx2}, 32'd1);
        @(negedge clock);
        check("held_restart_tx", {31'd0, tx2}, 32'd0);
        check("held_restart_busy", {31'd0, busy2}, 32'd1);
        n = 0;
        while (busy2 === 1'b1 && n < 1000) begin
            n++;
            @(negedge clock);
        end
        dump_req2 = 1'b0;
        check("held_busy_len", n, 360);
        check("held_done2", {31'd0, done2}, 32'd1);
        repeat (30) @(negedge clock);
        check("held_stopped", {31'd0, busy2}, 32'd0);
        check("held_done_count", done2_cnt - d0, 2);
        check("q_empty", q.size(), 0);
        check("q2_empty", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
